// File: rtl/demux_seq_pkg.sv
// Shared types and helpers for the framed serial driver that feeds the 1-to-4 demux.
package demux_seq_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } seq_state_t;

   typedef logic [1:0] chan_t;

   // Cycles from start-bit onset to the end of the stop bit.
   function automatic int frame_cycles(input int data_w, input int bit_div);
      return (data_w + 2) * bit_div;
   endfunction

endpackage

// File: rtl/demux_frame_sequencer_if.sv
// Upstream byte handshake: a valid/ready transfer of one data word plus its destination channel.
interface demux_frame_sequencer_if #(
   parameter int DATA_W = 8
);
   import demux_seq_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   chan_t             in_chan;

   modport master (
      output in_valid,
      output in_data,
      output in_chan,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_chan,
      output in_ready
   );

endinterface

// File: rtl/bit_timer.sv
// Bit-period divider: tick marks the last cycle of each BIT_DIV-cycle period while run is high.
module bit_timer #(
   parameter int BIT_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

   logic [CNT_W-1:0] cnt_reg;
   logic [CNT_W-1:0] cnt_next;
   logic             at_end;

   assign at_end = (cnt_reg == CNT_W'(BIT_DIV - 1));
   assign tick   = run && at_end;

   // Holding at zero while stopped makes the first period after run rises a full one.
   always_comb begin
      cnt_next = cnt_reg;
      if (!run || at_end) begin
         cnt_next = '0;
      end else begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

endmodule

// File: rtl/demux_frame_sequencer.sv
// Serialises channel-tagged bytes as start/data(LSB first)/stop frames on D, holding sel for the whole frame.
module demux_frame_sequencer
   import demux_seq_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int BIT_DIV = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   demux_frame_sequencer_if.slave    in_bus,
   output logic                      D,
   output chan_t                     sel,
   output logic                      busy,
   output logic                      frame_done
);

   localparam logic [1:0] S_IDLE  = IDLE;
   localparam logic [1:0] S_START = START;
   localparam logic [1:0] S_DATA  = DATA;
   localparam logic [1:0] S_STOP  = STOP;

   localparam int FRAME_LEN = frame_cycles(DATA_W, BIT_DIV);
   localparam int POS_W     = $clog2(FRAME_LEN);
   localparam int IDX_W     = $clog2(DATA_W + 1);

   logic [1:0]        state_reg,      state_next;
   logic [DATA_W-1:0] hold_data_reg,  hold_data_next;
   chan_t             hold_chan_reg,  hold_chan_next;
   logic              hold_full_reg,  hold_full_next;
   logic [DATA_W-1:0] shift_reg,      shift_next;
   logic [IDX_W-1:0]  idx_reg,        idx_next;
   logic [POS_W-1:0]  pos_reg,        pos_next;
   logic              d_reg,          d_next;
   chan_t             sel_reg,        sel_next;
   logic              busy_reg,       busy_next;
   logic              frame_done_reg, frame_done_next;

   logic              tick;
   logic              transfer;
   logic              load;
   logic              last_bit;
   logic [DATA_W-1:0] shift_dn;

   bit_timer #(
      .BIT_DIV (BIT_DIV)
   ) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .run  (state_reg != S_IDLE),
      .tick (tick)
   );

   assign in_bus.in_ready = !hold_full_reg;

   assign transfer = in_bus.in_valid && !hold_full_reg;
   assign last_bit = (idx_reg == IDX_W'(DATA_W - 1));
   assign shift_dn = shift_reg >> 1;

   // A held byte starts a frame straight from IDLE, or chains onto the end of a stop bit.
   assign load = hold_full_reg &&
                 ((state_reg == S_IDLE) || ((state_reg == S_STOP) && tick));

   always_comb begin
      state_next     = state_reg;
      hold_data_next = hold_data_reg;
      hold_chan_next = hold_chan_reg;
      hold_full_next = hold_full_reg;
      shift_next     = shift_reg;
      idx_next       = idx_reg;
      pos_next       = pos_reg;
      d_next         = d_reg;
      sel_next       = sel_reg;

      if (transfer) begin
         hold_data_next = in_bus.in_data;
         hold_chan_next = in_bus.in_chan;
         hold_full_next = 1'b1;
      end

      if (state_reg != S_IDLE) begin
         pos_next = pos_reg + 1'b1;
      end

      case (state_reg)
         S_START: begin
            if (tick) begin
               state_next = S_DATA;
               idx_next   = '0;
               d_next     = shift_reg[0];
            end
         end
         S_DATA: begin
            if (tick) begin
               if (last_bit) begin
                  state_next = S_STOP;
                  d_next     = 1'b1;
               end else begin
                  shift_next = shift_dn;
                  idx_next   = idx_reg + 1'b1;
                  d_next     = shift_dn[0];
               end
            end
         end
         S_STOP: begin
            if (tick) begin
               state_next = S_IDLE;
               pos_next   = '0;
               d_next     = 1'b1;
            end
         end
         default: begin
            d_next = 1'b1;
         end
      endcase

      // Loading overrides the STOP exit so the next start bit follows with no idle gap.
      if (load) begin
         state_next     = S_START;
         shift_next     = hold_data_reg;
         sel_next       = hold_chan_reg;
         hold_full_next = 1'b0;
         pos_next       = '0;
         d_next         = 1'b0;
      end

      busy_next       = (state_next != S_IDLE);
      // Registered one cycle early so the pulse lands on the final stop-bit cycle.
      frame_done_next = (state_reg != S_IDLE) && (pos_reg == POS_W'(FRAME_LEN - 2));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= S_IDLE;
         hold_data_reg  <= '0;
         hold_chan_reg  <= '0;
         hold_full_reg  <= 1'b0;
         shift_reg      <= '0;
         idx_reg        <= '0;
         pos_reg        <= '0;
         d_reg          <= 1'b1;
         sel_reg        <= '0;
         busy_reg       <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         hold_data_reg  <= hold_data_next;
         hold_chan_reg  <= hold_chan_next;
         hold_full_reg  <= hold_full_next;
         shift_reg      <= shift_next;
         idx_reg        <= idx_next;
         pos_reg        <= pos_next;
         d_reg          <= d_next;
         sel_reg        <= sel_next;
         busy_reg       <= busy_next;
         frame_done_reg <= frame_done_next;
      end
   end

   assign D          = d_reg;
   assign sel        = sel_reg;
   assign busy       = busy_reg;
   assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Directed bench: an 8-bit/div-4 instance for the main scenarios and a 1-bit/div-1 instance for the minimum frame.
module tb_demux_frame_sequencer;
   import demux_seq_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   demux_frame_sequencer_if #(.DATA_W(8)) bus ();
   demux_frame_sequencer_if #(.DATA_W(1)) bus1 ();

   logic  d, busy, frame_done;
   chan_t sel;
   logic  d1, busy1, frame_done1;
   chan_t sel1;

   demux_frame_sequencer #(.DATA_W(8), .BIT_DIV(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_bus     (bus),
      .D          (d),
      .sel        (sel),
      .busy       (busy),
      .frame_done (frame_done)
   );

   demux_frame_sequencer #(.DATA_W(1), .BIT_DIV(1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_bus     (bus1),
      .D          (d1),
      .sel        (sel1),
      .busy       (busy1),
      .frame_done (frame_done1)
   );

   // Expected D at cycle pos of an 8-bit, 4-cycle-per-bit frame.
   function automatic logic exp_d(input logic [7:0] data, input int pos);
      int b;
      b = pos / 4;
      if (b == 0) return 1'b0;
      if (b >= 9) return 1'b1;
      return data[b-1];
   endfunction

   task automatic step;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.in_chan = '0;
      bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_chan = '0;
      repeat (3) step();
      rst = 1'b0;
      step();
      checks++; if (d !== 1'b1) begin errors++; $display("FAIL reset_d got=%b exp=1", d); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", sel); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
      checks++; if (d1 !== 1'b1) begin errors++; $display("FAIL reset_d1 got=%b exp=1", d1); end
      $display("reset: outputs checked after release");
   endtask

   task automatic test_idle;
      for (int i = 0; i < 20; i++) begin
         checks++;
         if ({d, sel, busy, bus.in_ready} !== 5'b1_00_0_1) begin
            errors++;
            $display("FAIL idle cyc=%0d got D=%b sel=%0d busy=%b rdy=%b exp D=1 sel=0 busy=0 rdy=1",
                     i, d, sel, busy, bus.in_ready);
         end
         step();
      end
      $display("idle: 20 cycles checked");
   endtask

   task automatic test_single;
      logic [9:0] a5_seq;
      int         fd_count;
      a5_seq = 10'b1_10100101_0;
      fd_count = 0;
      bus.in_valid = 1'b1; bus.in_data = 8'hA5; bus.in_chan = 2'd2;
      step();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL single_accept in_ready got=%b exp=0", bus.in_ready); end
      bus.in_valid = 1'b0;
      step();
      for (int i = 0; i < frame_cycles(8, 4); i++) begin
         checks++; if (d !== a5_seq[i/4]) begin errors++; $display("FAIL single_d cyc=%0d got=%b exp=%b", i, d, a5_seq[i/4]); end
         checks++; if (sel !== 2'd2) begin errors++; $display("FAIL single_sel cyc=%0d got=%0d exp=2", i, sel); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy cyc=%0d got=%b exp=1", i, busy); end
         checks++; if (frame_done !== (i == 39)) begin errors++; $display("FAIL single_frame_done cyc=%0d got=%b exp=%b", i, frame_done, (i == 39)); end
         if (frame_done === 1'b1) fd_count++;
         step();
      end
      checks++; if (fd_count != 1) begin errors++; $display("FAIL single_fd_count got=%0d exp=1", fd_count); end
      checks++; if ({d, busy, frame_done} !== 3'b100) begin errors++; $display("FAIL single_back_idle got D=%b busy=%b fd=%b exp D=1 busy=0 fd=0", d, busy, frame_done); end
      $display("single: 0xA5 ch2 frame checked");
   endtask

   task automatic test_back_to_back;
      logic [7:0] dat;
      chan_t      ch;
      int         p;
      bus.in_valid = 1'b1; bus.in_data = 8'h01; bus.in_chan = 2'd0;
      step();
      bus.in_data = 8'hFF; bus.in_chan = 2'd3;
      step();
      for (int i = 0; i < 80; i++) begin
         p   = i % 40;
         dat = (i < 40) ? 8'h01 : 8'hFF;
         ch  = (i < 40) ? 2'd0 : 2'd3;
         checks++; if (d !== exp_d(dat, p)) begin errors++; $display("FAIL b2b_d cyc=%0d got=%b exp=%b", i, d, exp_d(dat, p)); end
         checks++; if (sel !== ch) begin errors++; $display("FAIL b2b_sel cyc=%0d got=%0d exp=%0d", i, sel, ch); end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy cyc=%0d got=%b exp=1", i, busy); end
         checks++; if (frame_done !== (p == 39)) begin errors++; $display("FAIL b2b_frame_done cyc=%0d got=%b exp=%b", i, frame_done, (p == 39)); end
         if (i == 1) bus.in_valid = 1'b0;
         step();
      end
      checks++; if ({d, busy} !== 2'b10) begin errors++; $display("FAIL b2b_back_idle got D=%b busy=%b exp D=1 busy=0", d, busy); end
      $display("back_to_back: 0x01 ch0 then 0xFF ch3 checked");
   endtask

   task automatic test_backpressure;
      logic [7:0] dat;
      chan_t      ch;
      logic       exp_rdy;
      int         p;
      bus.in_valid = 1'b1; bus.in_data = 8'h3C; bus.in_chan = 2'd1;
      step();
      bus.in_data = 8'h5A; bus.in_chan = 2'd2;
      step();
      for (int i = 0; i < 120; i++) begin
         p = i % 40;
         case (i / 40)
            0:       begin dat = 8'h3C; ch = 2'd1; end
            1:       begin dat = 8'h5A; ch = 2'd2; end
            default: begin dat = 8'hC3; ch = 2'd0; end
         endcase
         exp_rdy = (i <= 80) ? (p == 0) : 1'b1;
         checks++; if (d !== exp_d(dat, p)) begin errors++; $display("FAIL bp_d cyc=%0d got=%b exp=%b", i, d, exp_d(dat, p)); end
         checks++; if (sel !== ch) begin errors++; $display("FAIL bp_sel cyc=%0d got=%0d exp=%0d", i, sel, ch); end
         checks++; if (bus.in_ready !== exp_rdy) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=%b", i, bus.in_ready, exp_rdy); end
         if (i == 1) begin bus.in_data = 8'hC3; bus.in_chan = 2'd0; end
         if (i == 41) bus.in_valid = 1'b0;
         step();
      end
      checks++; if ({d, busy} !== 2'b10) begin errors++; $display("FAIL bp_back_idle got D=%b busy=%b exp D=1 busy=0", d, busy); end
      $display("backpressure: 0x3C, 0x5A, 0xC3 order checked");
   endtask

   task automatic test_reset_mid;
      int bad;
      bus.in_valid = 1'b1; bus.in_data = 8'h00; bus.in_chan = 2'd1;
      step();
      bus.in_data = 8'h81; bus.in_chan = 2'd3;
      step();
      for (int i = 0; i < 15; i++) begin
         if (i == 1) bus.in_valid = 1'b0;
         step();
      end
      checks++; if ({d, sel, busy} !== 4'b0_01_1) begin errors++; $display("FAIL rstmid_pre got D=%b sel=%0d busy=%b exp D=0 sel=1 busy=1", d, sel, busy); end
      rst = 1'b1;
      step();
      checks++; if (d !== 1'b1) begin errors++; $display("FAIL rstmid_d got=%b exp=1", d); end
      checks++; if (sel !== 2'd0) begin errors++; $display("FAIL rstmid_sel got=%0d exp=0", sel); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_frame_done got=%b exp=0", frame_done); end
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", bus.in_ready); end
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if ({d, busy, frame_done} !== 3'b100) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_held_dropped active_cycles got=%0d exp=0", bad); end
      $display("reset_mid: frame aborted, held byte discarded");
   endtask

   task automatic test_min_frame;
      logic [2:0] exp_dv;
      logic [2:0] exp_fd;
      exp_dv = 3'b110;
      exp_fd = 3'b100;
      bus1.in_valid = 1'b1; bus1.in_data = 1'b1; bus1.in_chan = 2'd3;
      step();
      bus1.in_valid = 1'b0;
      step();
      for (int i = 0; i < frame_cycles(1, 1); i++) begin
         checks++; if (d1 !== exp_dv[i]) begin errors++; $display("FAIL min_d cyc=%0d got=%b exp=%b", i, d1, exp_dv[i]); end
         checks++; if (frame_done1 !== exp_fd[i]) begin errors++; $display("FAIL min_frame_done cyc=%0d got=%b exp=%b", i, frame_done1, exp_fd[i]); end
         checks++; if ({busy1, sel1} !== 3'b1_11) begin errors++; $display("FAIL min_busy_sel cyc=%0d got busy=%b sel=%0d exp busy=1 sel=3", i, busy1, sel1); end
         step();
      end
      checks++; if ({d1, busy1, frame_done1} !== 3'b100) begin errors++; $display("FAIL min_back_idle got D=%b busy=%b fd=%b exp D=1 busy=0 fd=0", d1, busy1, frame_done1); end
      $display("min_frame: DATA_W=1 BIT_DIV=1 frame checked");
   endtask

   initial begin
      test_reset();
      test_idle();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_min_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/demux_frame_sequencer.md
# demux_frame_sequencer

Upstream driver for the 1-to-4 serial demultiplexer. It accepts bytes tagged with a 2-bit destination channel over a valid/ready handshake and serialises each byte as a framed bit stream on `D`. Framing is one start bit, `DATA_W` data bits LSB-first, then one stop bit. It holds `sel` stable at the destination channel for the whole frame, so the demux routes each complete frame to exactly one output line.

## Interface
Parameters:
- `DATA_W`, 8: data bits per frame; must be at least 1.
- `BIT_DIV`, 4: clock cycles per serial bit; must be at least 1.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_valid`  in  1  upstream has a byte.
- `in_ready`  out  1  block can accept a byte.
- `in_data`  in  DATA_W  byte to send.
- `in_chan`  in  2  destination channel, 0..3.
- `D`  out  1  serial data to the demux; idle level is 1.
- `sel`  out  2  demux select; stable for the entire frame.
- `busy`  out  1  high in START, DATA and STOP.
- `frame_done`  out  1  one-cycle pulse at the end of each stop bit.

## Operation
- Holding register: one entry, containing `hold_data`, `hold_chan` and `hold_full`.
  - `in_ready` = !`hold_full`.
  - Transfer occurs on an edge where `in_valid` && `in_ready`; that edge sets `hold_full`.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - `D`=1.
  - If `hold_full`: load the shift register from `hold_data`, set `sel` <= `hold_chan`, clear `hold_full`, and go to START.
- START: `D`=0 for `BIT_DIV` cycles, then go to DATA with bit index 0.
- DATA:
  - `D` = `shift[0]`.
  - Every `BIT_DIV` cycles, shift right and increment the index.
  - After `DATA_W` bits, go to STOP.
- STOP:
  - `D`=1 for `BIT_DIV` cycles.
  - On the final cycle, pulse `frame_done`.
  - If `hold_full` is set on that cycle, load the next byte and go directly to START with no idle gap. Otherwise go to IDLE.
- Simultaneous events:
  - A transfer and a load on the same edge cannot occur, because a transfer requires an empty holding register and a load requires a full one.
  - A byte accepted during a frame waits in the holding register. `in_ready` stays low until that byte is loaded.
- Channel changes: `sel` updates only on the IDLE->START or STOP->START edge. It never changes mid-frame.
- Widths:
  - Bit index counter: $clog2(`DATA_W`+1) bits.
  - Bit-period counter: $clog2(`BIT_DIV`) bits, minimum 1; wraps from `BIT_DIV`-1 to 0.

## Timing
- All outputs are registered, except `in_ready`, which is decoded from the `hold_full` register.
- Reset values:
  - `D`=1, `sel`=0, `busy`=0, `frame_done`=0, `in_ready`=1 on the cycle after reset releases.
  - FSM in IDLE, `hold_full`=0, counters 0.
- Latency: byte accepted at edge k; start bit driven on `D` after edge k+1.
- Frame length: (`DATA_W`+2)*`BIT_DIV` cycles, measured from start-bit onset to the end of the stop bit.
- Back-to-back streaming: sustained throughput is one byte per frame length with zero idle cycles, provided the upstream refills the holding register at least one cycle before the stop bit ends.
- `frame_done` is high on the same cycle as the last stop-bit cycle.
- Reset mid-frame: the frame aborts at once and `D` returns to 1. No `frame_done` is issued, and a held byte is discarded.

## Structure
- Package `demux_seq_pkg` contains:
  - state enum `seq_state_t` {IDLE, START, DATA, STOP};
  - channel type `chan_t` (logic [1:0]);
  - function `frame_cycles(DATA_W, BIT_DIV)`, shared by RTL and testbench.
- Sub-module `bit_timer`:
  - parameter `BIT_DIV`; inputs `clk`, `rst`, `run`; output `tick`.
  - `tick` is high on the last cycle of each bit period.
  - Restarts at 0 whenever `run` is low.

## Test plan
- Reset, then idle: `D`=1, `sel`=0, `busy`=0 and `in_ready`=1 held for 20 cycles.
- Single byte 0xA5 on channel 2 with `BIT_DIV`=4:
  - `D` sequence, one bit per 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - `sel`=2 for all 40 cycles.
  - One `frame_done` pulse; then back to IDLE.
- Back-to-back: 0x01 on channel 0 then 0xFF on channel 3, with `in_valid` held high.
  - Second start bit immediately follows the first stop bit.
  - `sel` goes 0->3 exactly at the frame boundary.
  - Two `frame_done` pulses spaced 40 cycles apart.
- Backpressure: while byte 1 is sending and byte 2 is held, `in_ready`=0.
  - Byte 3 is stable on `in_valid` and is not accepted until byte 2 loads.
  - Byte order is preserved.
- Reset asserted mid-DATA:
  - Next cycle: `D`=1, `sel`=0, `busy`=0, no `frame_done`.
  - The held byte is never sent.
- `BIT_DIV`=1, `DATA_W`=1, byte 1:
  - 3-cycle frame with `D` = 0,1,1.
  - `frame_done` on the third cycle.
